// File: rtl/parity_tx_pkg.sv
// Shared types and helpers for the parity serial transmitter.
// Holds the FSM state encoding and the parity calculation.
package parity_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam int DATA_W_DEFAULT = 4;
    localparam int MAX_W          = 32;
    localparam int FRAME_BITS     = DATA_W_DEFAULT + 3;

    // Start + data + parity + stop for a given data width
    function automatic int frame_bits(input int dw);
        return dw + 3;
    endfunction

    // Zero-extended data does not change the XOR reduction
    function automatic logic calc_parity(
        input logic [MAX_W-1:0] data,
        input logic             odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_serial_tx_bit_timer.sv
// Bit-period counter for the parity serial transmitter.
// tick marks the last cycle of a bit; near marks the cycle before it.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic near
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // With one cycle per bit every cycle is a wrap cycle
    assign near = (CLKS_PER_BIT == 1) ? 1'b1 : ((cnt_q == PRE) && !clr);

    // Next count: hold at zero while cleared, wrap after the last cycle
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/parity_serial_tx.sv
// Serial frame transmitter: start, data MSB-first, parity, stop.
// Also presents the parity bit in parallel for loopback into a checker.
module parity_serial_tx
    import parity_tx_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int ODD_PARITY   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              tx,
    output logic              par_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic ODD = (ODD_PARITY != 0);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              tx_q, tx_d;
    logic              par_q, par_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              tick;
    logic              near;
    logic              clr;

    // Timer is held at zero while idle so START gets a full bit period
    assign clr = (state_q == IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .tick(tick),
        .near(near)
    );

    assign in_ready   = (state_q == IDLE) && !rst;
    assign tx         = tx_q;
    assign par_out    = par_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    // Next-state, next-output and datapath logic of the frame FSM
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        par_d   = par_q;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (in_valid) begin
                    shift_d = in_data;
                    par_d   = calc_parity(MAX_W'(in_data), ODD);
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    bit_d   = '0;
                    tx_d    = shift_q[DATA_W-1];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        tx_d    = par_q;
                        state_d = PARITY;
                    end else begin
                        shift_d = shift_q << 1;
                        bit_d   = bit_q + BW'(1);
                        tx_d    = shift_d[DATA_W-1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && near;
    end

    // FSM and registered outputs; reset overrides any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            par_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            par_q   <= par_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx.
// Three instances: even/4 cycles, odd/4 cycles, even/1 cycle.
module tb_parity_serial_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       v0, v1, v2;
    logic [3:0] d0, d1, d2;
    logic       rdy0, tx0, par0, busy0, fd0;
    logic       rdy1, tx1, par1, busy1, fd1;
    logic       rdy2, tx2, par2, busy2, fd2;

    int n_chk  = 0;
    int n_pass = 0;

    parity_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(4), .ODD_PARITY(0)) dut (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0),
        .in_data(d0), .tx(tx0), .par_out(par0), .busy(busy0),
        .frame_done(fd0)
    );

    parity_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(4), .ODD_PARITY(1)) dut_odd (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1),
        .in_data(d1), .tx(tx1), .par_out(par1), .busy(busy1),
        .frame_done(fd1)
    );

    parity_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .ODD_PARITY(0)) dut_c1 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2),
        .in_data(d2), .tx(tx2), .par_out(par2), .busy(busy2),
        .frame_done(fd2)
    );

    task automatic send_main(input logic [3:0] d);
        @(negedge clk);
        v0 = 1'b1;
        d0 = d;
        n_chk++;
        if (rdy0 !== 1'b1) $display("FAIL send_ready got %b exp 1", rdy0);
        else n_pass++;
        @(posedge clk);
        #1 v0 = 1'b0;
    endtask

    // Call right after the accept edge; checks cycles t+1..t+28
    task automatic check_frame(input string nm, input logic [3:0] d,
                               input logic p, input bit chg);
        logic [6:0] bits;
        bits = {1'b0, d, p, 1'b1};
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            n_chk++;
            if (tx0 !== bits[6-k/4])
                $display("FAIL %s_tx k=%0d got %b exp %b", nm, k, tx0, bits[6-k/4]);
            else n_pass++;
            n_chk++;
            if (fd0 !== 1'(k == 27))
                $display("FAIL %s_done k=%0d got %b exp %b", nm, k, fd0, k == 27);
            else n_pass++;
            n_chk++;
            if (busy0 !== 1'b1)
                $display("FAIL %s_busy k=%0d got %b exp 1", nm, k, busy0);
            else n_pass++;
            if (chg) d0 = 4'(k * 5 + 3);
        end
    endtask

    task automatic check_idle(input string nm);
        n_chk++;
        if ({tx0, busy0, rdy0, fd0} !== 4'b1010)
            $display("FAIL %s_idle got tx/busy/rdy/done=%b exp 1010", nm,
                     {tx0, busy0, rdy0, fd0});
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v0 = 1'b1; d0 = 4'b1011;
        v1 = 1'b0; d1 = 4'b0000;
        v2 = 1'b0; d2 = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({tx0, busy0, fd0, par0, rdy0} !== 5'b10000)
            $display("FAIL rst_hold got %b exp 10000", {tx0, busy0, fd0, par0, rdy0});
        else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        v0 = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({tx0, busy0, fd0, par0, rdy0} !== 5'b10001)
            $display("FAIL rst_release got %b exp 10001", {tx0, busy0, fd0, par0, rdy0});
        else n_pass++;
    endtask

    task automatic test_even_1011();
        send_main(4'b1011);
        n_chk++;
        if (par0 !== 1'b1) $display("FAIL par_1011 got %b exp 1", par0);
        else n_pass++;
        check_frame("f1011", 4'b1011, 1'b1, 1'b0);
        @(negedge clk);
        check_idle("f1011");
        n_chk++;
        if (par0 !== 1'b1) $display("FAIL par_hold got %b exp 1", par0);
        else n_pass++;
    endtask

    task automatic test_parity_zero();
        logic [6:0] bits;
        send_main(4'b0000);
        n_chk++;
        if (par0 !== 1'b0) $display("FAIL par_even0 got %b exp 0", par0);
        else n_pass++;
        check_frame("f0000", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        check_idle("f0000");
        @(negedge clk);
        v1 = 1'b1; d1 = 4'b0000;
        @(posedge clk);
        #1 v1 = 1'b0;
        n_chk++;
        if (par1 !== 1'b1) $display("FAIL par_odd0 got %b exp 1", par1);
        else n_pass++;
        bits = 7'b0000011;
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            n_chk++;
            if (tx1 !== bits[6-k/4])
                $display("FAIL odd_tx k=%0d got %b exp %b", k, tx1, bits[6-k/4]);
            else n_pass++;
        end
        @(negedge clk);
        n_chk++;
        if ({busy1, rdy1} !== 2'b01)
            $display("FAIL odd_idle got busy/rdy=%b exp 01", {busy1, rdy1});
        else n_pass++;
    endtask

    task automatic test_loopback();
        logic [3:0] d;
        logic       p_exp;
        for (int n = 0; n < 16; n++) begin
            d = 4'(n);
            p_exp = d[0] ^ d[1] ^ d[2] ^ d[3];
            send_main(d);
            n_chk++;
            if (par0 !== p_exp)
                $display("FAIL lb_par d=%h got %b exp %b", d, par0, p_exp);
            else n_pass++;
            n_chk++;
            if ((^{d, par0}) !== 1'b0)
                $display("FAIL lb_pec d=%h got %b exp 0", d, ^{d, par0});
            else n_pass++;
            n_chk++;
            if ((^{d, ~par0}) !== 1'b1)
                $display("FAIL lb_pec_inv d=%h got %b exp 1", d, ^{d, ~par0});
            else n_pass++;
            repeat (28) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        v0 = 1'b1;
        d0 = 4'b1100;
        @(posedge clk);
        #1;
        check_frame("b2b_a", 4'b1100, 1'b0, 1'b1);
        @(negedge clk);
        check_idle("b2b_gap");
        d0 = 4'b0111;
        check_frame("b2b_b", 4'b0111, 1'b1, 1'b1);
        @(negedge clk);
        check_idle("b2b_end");
        v0 = 1'b0;
        @(negedge clk);
        check_idle("b2b_stop");
    endtask

    task automatic test_reset_mid();
        int pulses;
        send_main(4'b1011);
        repeat (10) @(negedge clk);
        n_chk++;
        if (tx0 !== 1'b0) $display("FAIL mid_bitB got %b exp 0", tx0);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("mid_rst");
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (fd0 === 1'b1 || tx0 !== 1'b1) pulses++;
        end
        n_chk++;
        if (pulses !== 0) $display("FAIL mid_quiet got %0d events exp 0", pulses);
        else n_pass++;
        send_main(4'b0110);
        check_frame("mid_new", 4'b0110, 1'b0, 1'b0);
        @(negedge clk);
        check_idle("mid_new");
    endtask

    task automatic test_cpb1();
        logic [6:0] bits;
        bits = 7'b0011001;
        @(negedge clk);
        v2 = 1'b1;
        d2 = 4'b0110;
        @(posedge clk);
        #1 v2 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            n_chk++;
            if (tx2 !== bits[6-k])
                $display("FAIL c1_tx k=%0d got %b exp %b", k, tx2, bits[6-k]);
            else n_pass++;
            n_chk++;
            if (fd2 !== 1'(k == 6))
                $display("FAIL c1_done k=%0d got %b exp %b", k, fd2, k == 6);
            else n_pass++;
        end
        @(negedge clk);
        n_chk++;
        if ({tx2, busy2, rdy2, fd2} !== 4'b1010)
            $display("FAIL c1_idle got %b exp 1010", {tx2, busy2, rdy2, fd2});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_even_1011();
        test_parity_zero();
        test_loopback();
        test_back_to_back();
        test_reset_mid();
        test_cpb1();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
